// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the BCD time-display to binary converter.
// Optional digit validity checking is enabled with BCD2BIN_DIGIT_CHECK_EN.
package bcd2bin_pkg;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned BCD_W          = 4 * DIGIT_W;
  localparam int unsigned MIN_W          = 4;
  localparam int unsigned STEP_W         = 4;
  localparam int unsigned SHIFT_STEPS    = 16;
  localparam int unsigned CS_PER_MIN_DEF = 6000;
  localparam int unsigned BIN_W_DEF      = 16;
  localparam int unsigned BCD_MAX        = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADD    = 2'd2,
    FINISH = 2'd3
  } state_e;

  // SS.cc digits, most significant first
  typedef struct packed {
    logic [DIGIT_W-1:0] d3;
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } bcd_word_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd2bin_bcd_digit_corr.sv
// Reverse double-dabble digit correction: any digit >= 8 after a right shift loses 3.
module bcd_digit_corr
  import bcd2bin_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout_c
);

  assign dout_c = (din >= DIGIT_W'(8)) ? (din - DIGIT_W'(3)) : din;

endmodule

// File: rtl/bcd2bin.sv
// Multi-cycle BCD (M:SS.cc) to binary hundredths converter with start/busy/done.
// Define BCD2BIN_DIGIT_CHECK_EN to add the err output flagging non-decimal digits.
module bcd2bin
  import bcd2bin_pkg::*;
#(
  parameter int unsigned CS_PER_MIN = CS_PER_MIN_DEF,
  parameter int unsigned BIN_W      = BIN_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIGIT_W-1:0] bcd0,
  input  logic [DIGIT_W-1:0] bcd1,
  input  logic [DIGIT_W-1:0] bcd2,
  input  logic [DIGIT_W-1:0] bcd3,
  input  logic [MIN_W-1:0]   minutes,
  output logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done
`ifdef BCD2BIN_DIGIT_CHECK_EN
  ,
  output logic               err
`endif
);

  state_e             state_q, state_d;
  bcd_word_t          bcd_q, bcd_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [MIN_W-1:0]   min_q, min_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic               err_q, err_d;
`endif

  bcd_word_t          bcd_shift;
  bcd_word_t          bcd_corr;
  logic [BIN_W-1:0]   acc_shift;

  // The work register is {bcd, acc}; one right shift moves bcd LSB into acc MSB
  assign bcd_shift = bcd_word_t'({1'b0, bcd_q[BCD_W-1:1]});
  assign acc_shift = {bcd_q[0], acc_q[BIN_W-1:1]};

  bcd_digit_corr u_corr3 (.din(bcd_shift.d3), .dout_c(bcd_corr.d3));
  bcd_digit_corr u_corr2 (.din(bcd_shift.d2), .dout_c(bcd_corr.d2));
  bcd_digit_corr u_corr1 (.din(bcd_shift.d1), .dout_c(bcd_corr.d1));
  bcd_digit_corr u_corr0 (.din(bcd_shift.d0), .dout_c(bcd_corr.d0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      step_q  <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      step_q  <= step_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    min_d   = min_q;
    step_d  = step_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = '{d3: bcd3, d2: bcd2, d1: bcd1, d0: bcd0};
          acc_d   = '0;
          min_d   = minutes;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_d   = digit_invalid(bcd0) | digit_invalid(bcd1) | digit_invalid(bcd2) |
                    digit_invalid(bcd3) | digit_invalid(minutes);
`endif
        end
      end

      SHIFT: begin
        bcd_d  = bcd_corr;
        acc_d  = acc_shift;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(SHIFT_STEPS - 1)) begin
          state_d = (min_q != '0) ? ADD : FINISH;
        end
      end

      // One minute's worth of hundredths per cycle; wraps mod 2^BIN_W on bad input
      ADD: begin
        acc_d = acc_q + BIN_W'(CS_PER_MIN);
        min_d = min_q - MIN_W'(1);
        if (min_q == MIN_W'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        bin_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: vector table, random conversions against an
// arithmetic model, and hand-written start/reset corner sequences.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3, minutes;
  logic [15:0] bin;
  logic        busy, done;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd2bin dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .minutes(minutes),
    .bin(bin), .busy(busy), .done(done)
`ifdef BCD2BIN_DIGIT_CHECK_EN
    , .err(err)
`endif
  );

  typedef struct {
    logic [3:0]  d3, d2, d1, d0, mn;
    logic [15:0] exp_bin;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: weighted decimal sum plus minutes*6000, wrapped to 16 bits
  function automatic logic [15:0] model(input int d3, d2, d1, d0, mn);
    int v;
    v = d3 * 1000 + d2 * 100 + d1 * 10 + d0 + mn * 6000;
    return 16'(v % 65536);
  endfunction

  // Called at a negedge with the DUT idle
  task automatic convert(input logic [3:0] d3, d2, d1, d0, mn, input logic [15:0] exp_bin,
                         input bit chk_bin, input string nm);
    int   n;
    logic busy_ok;
    logic exp_err;
    exp_err = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9) || (mn > 9);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0; minutes = mn; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcd3 = 4'($urandom); bcd2 = 4'($urandom); bcd1 = 4'($urandom);
    bcd0 = 4'($urandom); minutes = 4'($urandom);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    chk({nm, " err"}, 32'(err), 32'(exp_err));
`endif
    busy_ok = busy;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    chk({nm, " latency"}, 32'(n), 32'(17 + int'(mn)));
    chk({nm, " busy_during"}, 32'(busy_ok), 32'd1);
    chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
    if (chk_bin) chk({nm, " bin"}, 32'(bin), 32'(exp_bin));
    @(negedge clk);
    chk({nm, " done_width"}, 32'(done), 32'd0);
    if (chk_bin) chk({nm, " bin_held"}, 32'(bin), 32'(exp_bin));
  endtask

  initial begin
    int done_cnt, first_e, second_e;
    logic [15:0] first_bin, second_bin;
    bit launch_now;
    int d3, d2, d1, d0, mn;

    vecs[0] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0,  16'd0};
    vecs[1] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0,  16'd1234};
    vecs[2] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9,  16'd63999};
    vecs[3] = '{4'd5, 4'd9, 4'd9, 4'd9, 4'd3,  16'd23999};
    vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1,  16'd6000};
    vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd15, 16'd24465};
    vecs[6] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd15, 16'd34463};
    vecs[7] = '{4'd8, 4'd0, 4'd0, 4'd8, 4'd0,  16'd8008};

    rst_n = 1'b0; start = 1'b0;
    bcd0 = 4'd0; bcd1 = 4'd0; bcd2 = 4'd0; bcd3 = 4'd0; minutes = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset bin", 32'(bin), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    chk("reset err", 32'(err), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].mn,
              vecs[i].exp_bin, 1'b1, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      d3 = $urandom_range(0, 9); d2 = $urandom_range(0, 9);
      d1 = $urandom_range(0, 9); d0 = $urandom_range(0, 9);
      mn = $urandom_range(0, 15);
      convert(4'(d3), 4'(d2), 4'(d1), 4'(d0), 4'(mn), model(d3, d2, d1, d0, mn),
              1'b1, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Start re-pulsed while busy is ignored; start during done launches a new one
    bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0; minutes = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; first_e = 0; second_e = 0; first_bin = '0; second_bin = '0;
    launch_now = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      start = (e == 5) || (e == 10) || launch_now;
      launch_now = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_e = e; first_bin = bin; launch_now = 1'b1;
          bcd0 = 4'd7; minutes = 4'd0;
        end else begin
          second_e = e; second_bin = bin;
        end
      end
    end
    start = 1'b0;
    chk("repulse done_count", 32'(done_cnt), 32'd2);
    chk("repulse first_edge", 32'(first_e), 32'd18);
    chk("repulse first_bin", 32'(first_bin), 32'd6000);
    chk("chain second_edge", 32'(second_e), 32'd36);
    chk("chain second_bin", 32'(second_bin), 32'd7);

    // Reset in the middle of a conversion
    bcd3 = 4'd5; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9; minutes = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset bin", 32'(bin), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("midreset no_done", 32'(done_cnt), 32'd0);
    convert(4'd5, 4'd9, 4'd9, 4'd9, 4'd3, 16'd23999, 1'b1, "post_reset");

`ifdef BCD2BIN_DIGIT_CHECK_EN
    convert(4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 16'd0, 1'b0, "bad_digit");
    chk("bad_digit err_held", 32'(err), 32'd1);
    convert(4'd2, 4'd0, 4'd0, 4'd5, 4'd2, 16'd14005, 1'b1, "good_after_bad");
    chk("good err_held", 32'(err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
